alu_rezultat_fifo: RTL and testbench
====================================

ALU_REZULTAT_FIFO -- requirements
Module: alu_rezultat_fifo

Interface
Parameters
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the datapath width in bits (legal range 4..64).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the result-buffer entry count (legal values 2, 4, 8).

Ports
REQ-003 The block SHALL have port Clock, input, 1, sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port ResetN, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port Flush, input, 1, synchronous discard of all buffered results.
REQ-006 The block SHALL have port InValid, input, 1, operand/result set presented this cycle.
REQ-007 The block SHALL have port InReady, output, 1, block can accept a set this cycle.
REQ-008 The block SHALL have ports Hyrja0..Hyrja3, input, WIDTH each: AND, OR, XOR and adder result lanes respectively.
REQ-009 The block SHALL have port S, input, 3, lane select.
REQ-010 The block SHALL have port CarryIn, input, 1, adder carry-out accompanying Hyrja3.
REQ-011 The block SHALL have port OvfIn, input, 1, adder signed overflow accompanying Hyrja3.
REQ-012 The block SHALL have port OutValid, output, 1, head entry available.
REQ-013 The block SHALL have port OutReady, input, 1, consumer takes head entry this cycle.
REQ-014 The block SHALL have port Dalja, output, WIDTH, head result.
REQ-015 The block SHALL have port Flags, output, 4, head flags {N,Z,C,V} (bit3..bit0).
REQ-016 The block SHALL have port Count, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-017 Lane select SHALL be: S[2]=1 -> Hyrja3; S=3'b011 -> Hyrja2; S=3'b010 -> Hyrja1; S=3'b000 or 3'b001 -> Hyrja0.
REQ-018 Push SHALL occur when InValid && InReady; pop SHALL occur when OutValid && OutReady.
REQ-019 InReady SHALL be 1 exactly when Count < DEPTH (combinational from state only, not from OutReady).
REQ-020 OutValid SHALL be 1 exactly when Count > 0; Dalja and Flags SHALL be driven from the head entry registers, holding stable while OutValid=1 and OutReady=0.
REQ-021 Latency SHALL be one cycle: a set pushed at edge k into an empty buffer appears with OutValid=1 after edge k.
REQ-022 Each entry SHALL store the selected WIDTH-bit result plus flags computed at push: N = result[WIDTH-1]; Z = (result == 0); C = CarryIn and V = OvfIn when S[2]=1, otherwise C=0, V=0.
REQ-023 Entries SHALL leave in push order; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Simultaneous push and pop with 0 < Count < DEPTH SHALL leave Count unchanged.
REQ-025 When Count = DEPTH, no push SHALL occur even if OutReady=1 in the same cycle; the pop proceeds and Count becomes DEPTH-1.
REQ-026 When Count = 0, OutReady SHALL be ignored and Count SHALL not underflow.
REQ-027 Flush=1 SHALL set Count, read and write pointers to 0 at the next edge, discarding any same-cycle push and pop.
REQ-028 Dalja and Flags SHALL read 0 whenever OutValid=0.
REQ-029 Lane inputs, S, CarryIn and OvfIn SHALL be ignored in cycles without push.

Reset
REQ-030 ResetN=0 SHALL immediately, without a clock, set Count=0, pointers=0, OutValid=0, Dalja=0, Flags=4'b0000 and InReady=1.
REQ-031 Reset asserted mid-transfer SHALL discard all entries; after ResetN deasserts, the first push SHALL be the first entry output.
REQ-032 Entry storage contents SHALL not be required to reset, provided that REQ-028 holds.

Verification
REQ-033 The bench SHALL cover: WIDTH=16, push S=100, Hyrja3=16'h0000, CarryIn=1, OvfIn=0 -> next cycle OutValid=1, Dalja=16'h0000, Flags=4'b0110.
REQ-034 The bench SHALL cover: push S=011, Hyrja2=16'h8001, CarryIn=1, OvfIn=1 -> Dalja=16'h8001, Flags=4'b1000 (C and V masked).
REQ-035 The bench SHALL cover: DEPTH=2, OutReady=0, push A, B, then InValid on C -> InReady=0 after the second push, C not accepted; then drain -> A then B, Count 2->1->0.
REQ-036 The bench SHALL cover: Count=1, push and pop in the same cycle -> Count stays 1 and the new entry is at head next cycle.
REQ-037 The bench SHALL cover: Count=2, assert Flush with InValid=1 -> Count=0, OutValid=0, Dalja=0 next cycle.
REQ-038 The bench SHALL cover: Count=1, pulse ResetN low between edges -> OutValid=0 and Flags=0 before the next edge, InReady=1.

Source files
------------

// File: rtl/alu_rezultat_fifo.sv
// -----------------------------------------------------------------------------
// alu_rezultat_fifo
//
// Purpose:
//   Captures one ALU result per accepted transfer and queues it with its
//   condition flags. The result is picked from four precomputed lanes
//   (AND, OR, XOR, adder). The buffer is a small ring of DEPTH entries.
//   The head entry is presented with a valid/ready handshake.
//
// Parameters:
//   WIDTH  datapath width in bits (4..64)
//   DEPTH  number of buffered results (2, 4 or 8)
//
// Ports:
//   Clock            rising-edge clock for all state
//   ResetN           asynchronous active-low reset
//   Flush            synchronous discard of all buffered results
//   InValid/InReady  input handshake; a push happens when both are high
//   Hyrja0..Hyrja3   AND / OR / XOR / adder result lanes
//   S                lane select
//   CarryIn, OvfIn   adder carry-out and signed overflow (used with Hyrja3)
//   OutValid/OutReady output handshake; a pop happens when both are high
//   Dalja            head result (0 when empty)
//   Flags            head flags {N,Z,C,V} (0 when empty)
//   Count            current occupancy
// -----------------------------------------------------------------------------
module alu_rezultat_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     Clock,
  input  logic                     ResetN,
  input  logic                     Flush,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [WIDTH-1:0]         Hyrja0,
  input  logic [WIDTH-1:0]         Hyrja1,
  input  logic [WIDTH-1:0]         Hyrja2,
  input  logic [WIDTH-1:0]         Hyrja3,
  input  logic [2:0]               S,
  input  logic                     CarryIn,
  input  logic                     OvfIn,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [WIDTH-1:0]         Dalja,
  output logic [3:0]               Flags,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = WIDTH + 4;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] count_q,  count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic push;
  logic pop;

  // Ready depends only on occupancy, so a full buffer refuses a push even
  // when the consumer pops in the same cycle.
  assign InReady  = (count_q < FULL_COUNT);
  assign OutValid = (count_q != '0);

  assign push = InValid  && InReady;
  assign pop  = OutValid && OutReady;

  // ---------------------------------------------------------------------------
  // Lane select and flag generation for the entry being pushed
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   sel_result;
  logic [3:0]         sel_flags;
  logic [ENTRY_W-1:0] new_entry;

  always_comb begin
    sel_result = Hyrja0;
    if (S[2]) begin
      sel_result = Hyrja3;
    end else if (S[1:0] == 2'b11) begin
      sel_result = Hyrja2;
    end else if (S[1:0] == 2'b10) begin
      sel_result = Hyrja1;
    end
  end

  // Carry and overflow only mean something for the adder lane.
  always_comb begin
    sel_flags[3] = sel_result[WIDTH-1];
    sel_flags[2] = (sel_result == '0);
    sel_flags[1] = S[2] & CarryIn;
    sel_flags[0] = S[2] & OvfIn;
  end

  assign new_entry = {sel_result, sel_flags};

  // ---------------------------------------------------------------------------
  // Next-state logic for pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (Flush) begin
      // Flush wins over any push or pop in the same cycle.
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // The data registers carry no reset: an entry is only observable once it
  // has been written, and the output gating below hides stale contents.
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] entry_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic wr_en;
    assign wr_en = push && !Flush && (wr_ptr_q == PTR_W'(gi));

    always_ff @(posedge Clock) begin
      if (wr_en) begin
        entry_q[gi] <= new_entry;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] head_entry;

  assign head_entry = entry_q[rd_ptr_q];

  assign Dalja = OutValid ? head_entry[ENTRY_W-1:4] : '0;
  assign Flags = OutValid ? head_entry[3:0]         : 4'b0000;
  assign Count = count_q;

endmodule

// File: tb/tb_alu_rezultat_fifo.sv
// -----------------------------------------------------------------------------
// Bench for alu_rezultat_fifo (WIDTH=16, DEPTH=2).
// Expected entries are built from the stimulus and queued. Every cycle the
// head, occupancy and handshake outputs are checked against the queue before
// the active edge.
// -----------------------------------------------------------------------------
module tb_alu_rezultat_fifo;

  localparam int W     = 16;
  localparam int D     = 2;
  localparam int CNT_W = $clog2(D) + 1;

  logic             Clock    = 1'b0;
  logic             ResetN   = 1'b0;
  logic             Flush    = 1'b0;
  logic             InValid  = 1'b0;
  logic             OutReady = 1'b0;
  logic             CarryIn  = 1'b0;
  logic             OvfIn    = 1'b0;
  logic [2:0]       S        = 3'b000;
  logic [W-1:0]     Hyrja0   = '0;
  logic [W-1:0]     Hyrja1   = '0;
  logic [W-1:0]     Hyrja2   = '0;
  logic [W-1:0]     Hyrja3   = '0;
  logic             InReady;
  logic             OutValid;
  logic [W-1:0]     Dalja;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] Count;

  alu_rezultat_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .Flush    (Flush),
    .InValid  (InValid),
    .InReady  (InReady),
    .Hyrja0   (Hyrja0),
    .Hyrja1   (Hyrja1),
    .Hyrja2   (Hyrja2),
    .Hyrja3   (Hyrja3),
    .S        (S),
    .CarryIn  (CarryIn),
    .OvfIn    (OvfIn),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Dalja    (Dalja),
    .Flags    (Flags),
    .Count    (Count)
  );

  always #5 Clock = ~Clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard of {result, flags}, oldest first.
  logic [W+3:0] sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference entry straight from the lane/flag rules.
  function automatic logic [W+3:0] model_entry(
    input logic [2:0] s, input logic [W-1:0] h0, input logic [W-1:0] h1,
    input logic [W-1:0] h2, input logic [W-1:0] h3, input logic c, input logic v);
    logic [W-1:0] r;
    logic         is_add;
    is_add = s[2];
    if (is_add)              r = h3;
    else if (s == 3'b011)    r = h2;
    else if (s == 3'b010)    r = h1;
    else                     r = h0;
    return {r, r[W-1], (r == '0), is_add && c, is_add && v};
  endfunction

  task automatic set_in(input logic valid, input logic [2:0] s, input logic [W-1:0] h0,
                        input logic [W-1:0] h1, input logic [W-1:0] h2,
                        input logic [W-1:0] h3, input logic c, input logic v);
    InValid = valid;
    S       = s;
    Hyrja0  = h0;
    Hyrja1  = h1;
    Hyrja2  = h2;
    Hyrja3  = h3;
    CarryIn = c;
    OvfIn   = v;
  endtask

  // Check outputs against the model, then take one clock edge and update
  // the model with whatever push/pop the current inputs cause.
  task automatic cycle(input string tag);
    int           cnt;
    logic         do_push;
    logic         do_pop;
    logic [W+3:0] e;
    cnt = sb.size();
    check({tag, "/InReady"},  64'(InReady),  64'(cnt < D));
    check({tag, "/OutValid"}, 64'(OutValid), 64'(cnt > 0));
    check({tag, "/Count"},    64'(Count),    64'(cnt));
    if (cnt > 0) begin
      e = sb[0];
      check({tag, "/Dalja"}, 64'(Dalja), 64'(e[W+3:4]));
      check({tag, "/Flags"}, 64'(Flags), 64'(e[3:0]));
    end else begin
      check({tag, "/Dalja0"}, 64'(Dalja), 64'd0);
      check({tag, "/Flags0"}, 64'(Flags), 64'd0);
    end
    do_push = InValid && (cnt < D);
    do_pop  = OutReady && (cnt > 0);
    e = model_entry(S, Hyrja0, Hyrja1, Hyrja2, Hyrja3, CarryIn, OvfIn);
    @(posedge Clock);
    if (Flush) begin
      sb.delete();
    end else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(e);
    end
    #1;
    $display("[%0t] %s push=%0b pop=%0b flush=%0b entry=%h occupancy=%0d",
             $time, tag, do_push, do_pop, Flush, e, sb.size());
  endtask

  initial begin
    // Reset is active from time 0 with no clock edge yet.
    #2;
    check("rst/Count",    64'(Count),    64'd0);
    check("rst/OutValid", 64'(OutValid), 64'd0);
    check("rst/InReady",  64'(InReady),  64'd1);
    check("rst/Dalja",    64'(Dalja),    64'd0);
    check("rst/Flags",    64'(Flags),    64'd0);
    @(posedge Clock);
    #1;
    ResetN = 1'b1;

    // Popping an empty buffer must not underflow.
    OutReady = 1'b1;
    cycle("empty_pop");
    cycle("empty_pop2");
    check("empty/Count", 64'(Count), 64'd0);
    OutReady = 1'b0;

    // Adder lane, zero result, carry kept, overflow clear.
    set_in(1'b1, 3'b100, 16'h1234, 16'h5678, 16'h9abc, 16'h0000, 1'b1, 1'b0);
    cycle("add_zero");
    check("add_zero/OutValid", 64'(OutValid), 64'd1);
    check("add_zero/Dalja",    64'(Dalja),    64'h0000);
    check("add_zero/Flags",    64'(Flags),    64'b0110);
    // Lane inputs change without a push; head must hold.
    set_in(1'b0, 3'b011, 16'hffff, 16'hffff, 16'hffff, 16'hffff, 1'b1, 1'b1);
    cycle("hold");
    check("hold/Dalja", 64'(Dalja), 64'h0000);
    check("hold/Flags", 64'(Flags), 64'b0110);
    OutReady = 1'b1;
    cycle("pop_add_zero");
    OutReady = 1'b0;

    // XOR lane with carry/overflow masked.
    set_in(1'b1, 3'b011, 16'h0001, 16'h0002, 16'h8001, 16'h0004, 1'b1, 1'b1);
    cycle("xor_neg");
    set_in(1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0);
    check("xor_neg/Dalja", 64'(Dalja), 64'h8001);
    check("xor_neg/Flags", 64'(Flags), 64'b1000);

    // Count=1: pushes overlap pops, occupancy stays at 1 and new data surfaces.
    OutReady = 1'b1;
    set_in(1'b1, 3'b000, 16'h8000, 16'h1111, 16'h2222, 16'h3333, 1'b1, 1'b1);
    cycle("and_lane");
    check("pp1/Count", 64'(Count), 64'd1);
    check("pp1/Dalja", 64'(Dalja), 64'h8000);
    set_in(1'b1, 3'b001, 16'h0042, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b1);
    cycle("and_lane_s001");
    check("pp2/Count", 64'(Count), 64'd1);
    set_in(1'b1, 3'b010, 16'h4444, 16'h0000, 16'h2222, 16'h3333, 1'b1, 1'b0);
    cycle("or_lane_zero");
    set_in(1'b1, 3'b111, 16'h4444, 16'h5555, 16'h2222, 16'hfff0, 1'b1, 1'b1);
    cycle("add_s111");
    set_in(1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0);
    cycle("drain_one");

    // Fill without consumer: A, B accepted, C refused.
    OutReady = 1'b0;
    set_in(1'b1, 3'b100, 16'h0000, 16'h0000, 16'h0000, 16'haaaa, 1'b0, 1'b1);
    cycle("push_A");
    set_in(1'b1, 3'b010, 16'h0000, 16'h0bbb, 16'h0000, 16'h0000, 1'b0, 1'b0);
    cycle("push_B");
    check("full/InReady", 64'(InReady), 64'd0);
    check("full/Count",   64'(Count),   64'd2);
    set_in(1'b1, 3'b011, 16'h0000, 16'h0000, 16'hcccc, 16'h0000, 1'b0, 1'b0);
    cycle("refuse_C");
    check("refuse_C/Count", 64'(Count), 64'h2);
    check("refuse_C/Dalja", 64'(Dalja), 64'haaaa);
    set_in(1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0);
    OutReady = 1'b1;
    cycle("drain_A");
    check("drain_A/Count", 64'(Count), 64'd1);
    check("drain_A/Dalja", 64'(Dalja), 64'h0bbb);
    cycle("drain_B");
    check("drain_B/Count", 64'(Count), 64'd0);

    // Full with consumer ready: pop proceeds, push refused.
    OutReady = 1'b0;
    set_in(1'b1, 3'b000, 16'h0101, '0, '0, '0, 1'b0, 1'b0);
    cycle("fill1");
    set_in(1'b1, 3'b000, 16'h0202, '0, '0, '0, 1'b0, 1'b0);
    cycle("fill2");
    OutReady = 1'b1;
    set_in(1'b1, 3'b000, 16'h0303, '0, '0, '0, 1'b0, 1'b0);
    cycle("full_popush");
    check("full_popush/Count", 64'(Count), 64'd1);
    check("full_popush/Dalja", 64'(Dalja), 64'h0202);

    // Back to full, then flush with a push and pop offered.
    OutReady = 1'b0;
    set_in(1'b1, 3'b000, 16'h0404, '0, '0, '0, 1'b0, 1'b0);
    cycle("refill");
    check("refill/Count", 64'(Count), 64'd2);
    Flush    = 1'b1;
    OutReady = 1'b1;
    set_in(1'b1, 3'b000, 16'h0505, '0, '0, '0, 1'b0, 1'b0);
    cycle("flush");
    Flush    = 1'b0;
    OutReady = 1'b0;
    check("flush/Count",    64'(Count),    64'd0);
    check("flush/OutValid", 64'(OutValid), 64'd0);
    check("flush/Dalja",    64'(Dalja),    64'd0);
    set_in(1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0);
    cycle("post_flush");

    // Asynchronous reset pulse between edges with one entry held.
    set_in(1'b1, 3'b100, '0, '0, '0, 16'h8000, 1'b1, 1'b1);
    cycle("pre_rst");
    set_in(1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0);
    check("pre_rst/Flags", 64'(Flags), 64'b1011);
    ResetN = 1'b0;
    #1;
    check("arst/OutValid", 64'(OutValid), 64'd0);
    check("arst/Flags",    64'(Flags),    64'd0);
    check("arst/Dalja",    64'(Dalja),    64'd0);
    check("arst/InReady",  64'(InReady),  64'd1);
    check("arst/Count",    64'(Count),    64'd0);
    ResetN = 1'b1;
    sb.delete();
    #1;

    // First push after reset is the first entry out.
    set_in(1'b1, 3'b010, '0, 16'h7e7e, '0, '0, 1'b1, 1'b1);
    cycle("post_rst_push");
    check("post_rst/Dalja", 64'(Dalja), 64'h7e7e);
    set_in(1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0);
    OutReady = 1'b1;
    cycle("post_rst_pop");
    cycle("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
